// File: rtl/seq_detect_prog_if.sv
// Bus bundle for the programmable serial pattern detector: the serial stream,
// the configuration load and the match/counter status.
interface seq_detect_prog_if #(
  parameter int MAX_LEN = 8,
  parameter int CNT_W   = 8
);
  localparam int LW = $clog2(MAX_LEN + 1);

  logic               En;
  logic               j;
  logic               CfgLoad;
  logic [MAX_LEN-1:0] CfgPattern;
  logic [LW-1:0]      CfgLen;
  logic               CfgOverlap;
  logic               w;
  logic [CNT_W-1:0]   MatchCount;
  logic               CountSat;
  logic               CfgErr;

  modport master (
    output En, j, CfgLoad, CfgPattern, CfgLen, CfgOverlap,
    input  w, MatchCount, CountSat, CfgErr
  );

  modport slave (
    input  En, j, CfgLoad, CfgPattern, CfgLen, CfgOverlap,
    output w, MatchCount, CountSat, CfgErr
  );
endinterface

// File: rtl/seq_detect_prog.sv
// Programmable serial pattern detector: runtime-loadable 1..MAX_LEN bit pattern,
// overlap/non-overlap matching, registered match pulse and saturating count.
module seq_detect_prog #(
  parameter int                 MAX_LEN     = 8,
  parameter int                 CNT_W       = 8,
  parameter logic [MAX_LEN-1:0] DEF_PATTERN = MAX_LEN'(8'b00010010),
  parameter int                 DEF_LEN     = 5,
  parameter bit                 DEF_OVERLAP = 1'b1
) (
  input  logic              Clock,
  input  logic              Reset,
  seq_detect_prog_if.slave  bus
);
  localparam int          LW      = $clog2(MAX_LEN + 1);
  localparam logic [LW-1:0] LEN_MAX = LW'(MAX_LEN);
  localparam logic        DEF_ERR = (DEF_LEN == 0) || (DEF_LEN > MAX_LEN);

  // The oldest history bit is only ever needed as part of the shifted value,
  // so MAX_LEN-1 bits are stored and the newest bit is appended combinationally.
  logic [MAX_LEN-2:0] hist_q, hist_d;
  logic [LW-1:0]      fill_q, fill_d;
  logic [MAX_LEN-1:0] pat_q, pat_d;
  logic [LW-1:0]      len_q, len_d;
  logic               ovl_q, ovl_d;
  logic               err_q, err_d;
  logic               w_q, w_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               sat_q, sat_d;

  logic [MAX_LEN-1:0] hist_n;
  logic [LW-1:0]      fill_n;
  logic [MAX_LEN-1:0] mask;
  logic               match;

  // Only the low len bits of the pattern take part in the compare.
  for (genvar i = 0; i < MAX_LEN; i++) begin : g_mask
    assign mask[i] = (i < int'(len_q));
  end

  always_comb begin
    hist_n = {hist_q, bus.j};
    fill_n = (fill_q >= LEN_MAX) ? LEN_MAX : fill_q + 1'b1;
    match  = !err_q && (fill_n >= len_q) && (((hist_n ^ pat_q) & mask) == '0);

    hist_d = hist_q;
    fill_d = fill_q;
    pat_d  = pat_q;
    len_d  = len_q;
    ovl_d  = ovl_q;
    err_d  = err_q;
    cnt_d  = cnt_q;
    w_d    = 1'b0;

    if (bus.CfgLoad) begin
      pat_d  = bus.CfgPattern;
      len_d  = bus.CfgLen;
      ovl_d  = bus.CfgOverlap;
      err_d  = (bus.CfgLen == '0) || (bus.CfgLen > LEN_MAX);
      hist_d = '0;
      fill_d = '0;
      cnt_d  = '0;
    end else if (bus.En) begin
      hist_d = hist_n[MAX_LEN-2:0];
      // Non-overlap restarts the fill count; history keeps shifting regardless.
      fill_d = (match && !ovl_q) ? '0 : fill_n;
      w_d    = match;
      if (match && !(&cnt_q)) cnt_d = cnt_q + 1'b1;
    end

    sat_d = &cnt_d;
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      hist_q <= '0;
      fill_q <= '0;
      pat_q  <= DEF_PATTERN;
      len_q  <= LW'(DEF_LEN);
      ovl_q  <= DEF_OVERLAP;
      err_q  <= DEF_ERR;
      w_q    <= 1'b0;
      cnt_q  <= '0;
      sat_q  <= 1'b0;
    end else begin
      hist_q <= hist_d;
      fill_q <= fill_d;
      pat_q  <= pat_d;
      len_q  <= len_d;
      ovl_q  <= ovl_d;
      err_q  <= err_d;
      w_q    <= w_d;
      cnt_q  <= cnt_d;
      sat_q  <= sat_d;
    end
  end

  assign bus.w          = w_q;
  assign bus.MatchCount = cnt_q;
  assign bus.CountSat   = sat_q;
  assign bus.CfgErr     = err_q;
endmodule

// File: doc/seq_detect_prog.md
Name: seq_detect_prog

Overview:
Programmable serial pattern detector. It watches a one-bit serial stream and raises a one-cycle flag each time a runtime-loadable pattern of 1..MAX_LEN bits completes. Overlapping or non-overlapping matching is selectable, and a saturating match counter is kept. It is the parametrised next generation of the team's fixed 5-bit "10010" detector, used wherever serial framing or sync words must be spotted.

Parameters:
MAX_LEN, 8, maximum pattern length in bits (>=2)
CNT_W, 8, width of match counter
DEF_PATTERN, 8'b00010010, pattern loaded at reset (right-aligned)
DEF_LEN, 5, pattern length loaded at reset
DEF_OVERLAP, 1, overlap mode loaded at reset

Ports:
Clock  in  1  rising-edge clock
Reset  in  1  asynchronous, active-low reset
En  in  1  serial bit valid; j is sampled only when En=1
j  in  1  serial data bit
CfgLoad  in  1  latch new configuration this cycle
CfgPattern  in  MAX_LEN  pattern, right-aligned; bit CfgLen-1 = first bit received, bit 0 = last
CfgLen  in  $clog2(MAX_LEN+1)  pattern length
CfgOverlap  in  1  1 = overlapping matches allowed, 0 = history cleared after each match
w  out  1  registered one-cycle match pulse
MatchCount  out  CNT_W  number of matches since reset or last CfgLoad, saturating
CountSat  out  1  MatchCount at all-ones
CfgErr  out  1  active configuration invalid (length 0 or > MAX_LEN); detector disabled

Behaviour:
- Reset (Reset=0, async): history=0, fill=0, w=0, MatchCount=0, CountSat=0. Config = DEF_PATTERN/DEF_LEN/DEF_OVERLAP. CfgErr reflects the DEF_LEN validity.
- State: hist[MAX_LEN-1:0] shift register (newest bit at bit 0); fill counter 0..MAX_LEN, saturating at MAX_LEN.
- Cycle with En=1 and CfgLoad=0:
  - hist_n = {hist[MAX_LEN-2:0], j}; fill_n = min(fill+1, MAX_LEN).
  - match = !CfgErr && fill_n >= len && hist_n[len-1:0] == pat[len-1:0].
  - w <= match.
  - On match: MatchCount increments unless saturated.
  - On match with overlap=0: fill <= 0 (hist is still updated); otherwise fill <= fill_n.
- Cycle with En=0 and CfgLoad=0: hist, fill and MatchCount hold; w <= 0.
- Latency: w is high for exactly the one cycle after the edge that samples the final pattern bit.
- Back-to-back matches produce consecutive w pulses. Example: overlap mode, pattern 11, stream 1,1,1.
- CfgLoad=1 (has priority over En):
  - Latch pattern, length and overlap.
  - hist <= 0, fill <= 0, w <= 0, MatchCount <= 0.
  - A bit presented in the same cycle is discarded.
  - CfgErr <= (CfgLen==0 || CfgLen>MAX_LEN).
- CfgErr=1: w stays 0 and MatchCount holds, until a valid CfgLoad or reset.
- Pattern bits above len-1 are ignored.
- Reset asserted mid-stream: immediate return to default config, partial history lost. First valid sample after release is treated as bit 1.
- No combinational path from inputs to outputs.

Test Plan:
- Default config (10010, len 5, overlap); stream 1,0,0,1,0,0,1,0 with En=1 -> w pulses after bits 5 and 8; MatchCount=2.
- CfgLoad pattern 10010 len 5, overlap=0; same stream -> single w pulse after bit 5; MatchCount=1.
- CfgLoad pattern 101 len 3; stream 1,0,1,0,1:
  - overlap=1 -> pulses after bits 3 and 5.
  - overlap=0 -> pulse after bit 3 only.
  - Insert En=0 gaps of 1-3 cycles between bits -> same results; w=0 during gaps.
- CNT_W=2, pattern 11 len 2 overlap; stream of six 1s -> 5 w pulses; MatchCount stops at 3; CountSat=1 from the 3rd match. CfgLoad then clears both.
- CfgLoad with CfgLen=0 -> CfgErr=1; stream 1,0,0,1,0 -> no w. CfgLoad asserted together with En=1 -> that bit ignored, history cleared.
- Default config; drive 1,0,0,1 then pulse Reset low mid-cycle -> outputs 0 immediately. After release, bit 0 alone gives no w; a full 1,0,0,1,0 gives w after bit 5.
